// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl: sequencer for a four-unit MAXNET winner-take-all competition.
// Loads initial activations, waits for the processing-unit multiply/add
// stages, then feeds the returned ReLU outputs back until one unit survives.
// Optional build macro MAXNET_TIMEOUT_EN adds an iteration limit (MAX_ITER)
// and a timeout flag; without it, competition runs until at most one unit survives.
module maxnet_ctrl #(
  parameter int WAIT_CYCLES = 2
`ifdef MAXNET_TIMEOUT_EN
  ,parameter int MAX_ITER = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] X_in_0,
  input  logic [31:0] X_in_1,
  input  logic [31:0] X_in_2,
  input  logic [31:0] X_in_3,
  input  logic [31:0] PU_out_0,
  input  logic [31:0] PU_out_1,
  input  logic [31:0] PU_out_2,
  input  logic [31:0] PU_out_3,
  input  logic        Zero_sign_0,
  input  logic        Zero_sign_1,
  input  logic        Zero_sign_2,
  input  logic        Zero_sign_3,
  output logic [31:0] X_0,
  output logic [31:0] X_1,
  output logic [31:0] X_2,
  output logic [31:0] X_3,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [31:0] max_value,
  output logic [7:0]  iter_count
`ifdef MAXNET_TIMEOUT_EN
  ,output logic       timeout
`endif
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [3:0]        zs;
  logic [2:0]        nz;
  logic [1:0]        win_idx;
  logic [DATA_W-1:0] win_val;
  logic [7:0]        iter_inc;
  logic              multi;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign zs       = {Zero_sign_3, Zero_sign_2, Zero_sign_1, Zero_sign_0};
  assign iter_inc = sat_inc(iter_count);
  assign multi    = (nz >= 3'd2);
  assign busy     = (state == S_LOAD) || (state == S_WAIT) || (state == S_CHECK);
  assign done     = (state == S_DONE);

  // Survivor count and survivor selection; the index only matters when exactly one unit survives.
  always_comb begin
    nz      = 3'd0;
    win_idx = 2'd0;
    for (int i = 0; i < 4; i++) nz = nz + {2'b00, ~zs[i]};
    for (int i = 3; i >= 0; i--) if (!zs[i]) win_idx = 2'(i);
    case (win_idx)
      2'd0:    win_val = PU_out_0;
      2'd1:    win_val = PU_out_1;
      2'd2:    win_val = PU_out_2;
      default: win_val = PU_out_3;
    endcase
  end

  // Competition state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: start is honoured only from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_WAIT;
      S_WAIT:         if (wait_cnt == '0) state_nxt = S_CHECK;
      S_CHECK: begin
        if (multi) begin
          state_nxt = S_WAIT;
`ifdef MAXNET_TIMEOUT_EN
          if (iter_inc == 8'(MAX_ITER)) state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_DONE;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Activations, wait counter and result registers; reset aborts with no further X update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      X_0        <= '0;
      X_1        <= '0;
      X_2        <= '0;
      X_3        <= '0;
      wait_cnt   <= '0;
      winner     <= '0;
      max_value  <= '0;
      iter_count <= '0;
`ifdef MAXNET_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            X_0        <= X_in_0;
            X_1        <= X_in_1;
            X_2        <= X_in_2;
            X_3        <= X_in_3;
            iter_count <= '0;
`ifdef MAXNET_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
          end
        end
        S_LOAD: wait_cnt <= CNT_RELOAD;
        S_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        S_CHECK: begin
          X_0        <= PU_out_0;
          X_1        <= PU_out_1;
          X_2        <= PU_out_2;
          X_3        <= PU_out_3;
          iter_count <= iter_inc;
          if (multi) begin
            wait_cnt <= CNT_RELOAD;
`ifdef MAXNET_TIMEOUT_EN
            if (iter_inc == 8'(MAX_ITER)) begin
              timeout   <= 1'b1;
              winner    <= '0;
              max_value <= '0;
            end
`endif
          end else if (nz == 3'd1) begin
            winner    <= win_idx;
            max_value <= win_val;
          end else begin
            winner    <= '0;
            max_value <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// tb_maxnet_ctrl: directed-vector bench for maxnet_ctrl (WAIT_CYCLES=2).
// The processing units are modelled by driving PU_out/Zero_sign ahead of each CHECK.
module tb_maxnet_ctrl;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] X_in_0, X_in_1, X_in_2, X_in_3;
  logic [31:0] PU_out_0, PU_out_1, PU_out_2, PU_out_3;
  logic        Zero_sign_0, Zero_sign_1, Zero_sign_2, Zero_sign_3;
  logic [31:0] X_0, X_1, X_2, X_3;
  logic        busy, done;
  logic [1:0]  winner;
  logic [31:0] max_value;
  logic [7:0]  iter_count;
`ifdef MAXNET_TIMEOUT_EN
  logic        timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxnet_ctrl #(
    .WAIT_CYCLES(WC)
`ifdef MAXNET_TIMEOUT_EN
    ,.MAX_ITER(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .X_in_0(X_in_0), .X_in_1(X_in_1), .X_in_2(X_in_2), .X_in_3(X_in_3),
    .PU_out_0(PU_out_0), .PU_out_1(PU_out_1), .PU_out_2(PU_out_2), .PU_out_3(PU_out_3),
    .Zero_sign_0(Zero_sign_0), .Zero_sign_1(Zero_sign_1),
    .Zero_sign_2(Zero_sign_2), .Zero_sign_3(Zero_sign_3),
    .X_0(X_0), .X_1(X_1), .X_2(X_2), .X_3(X_3),
    .busy(busy), .done(done), .winner(winner), .max_value(max_value),
    .iter_count(iter_count)
`ifdef MAXNET_TIMEOUT_EN
    ,.timeout(timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_x(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, ".X_0"}, X_0, e0);
    chk({tag, ".X_1"}, X_1, e1);
    chk({tag, ".X_2"}, X_2, e2);
    chk({tag, ".X_3"}, X_3, e3);
  endtask

  task automatic chk_st(input string tag, input logic b, input logic d,
                        input logic [1:0] w, input logic [7:0] it);
    chk({tag, ".busy"},   32'(busy),       32'(b));
    chk({tag, ".done"},   32'(done),       32'(d));
    chk({tag, ".winner"}, 32'(winner),     32'(w));
    chk({tag, ".iter"},   32'(iter_count), 32'(it));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pu(input logic [3:0] zs, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3);
    {Zero_sign_3, Zero_sign_2, Zero_sign_1, Zero_sign_0} = zs;
    PU_out_0 = p0; PU_out_1 = p1; PU_out_2 = p2; PU_out_3 = p3;
  endtask

  // Drives a one-cycle start; on return the DUT is in LOAD.
  task automatic pulse_start(input logic [31:0] x0, input logic [31:0] x1,
                             input logic [31:0] x2, input logic [31:0] x3);
    X_in_0 = x0; X_in_1 = x1; X_in_2 = x2; X_in_3 = x3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    X_in_0 = '0; X_in_1 = '0; X_in_2 = '0; X_in_3 = '0;
    set_pu(4'hF, '0, '0, '0, '0);
    tick(2);
    chk_x("rst", 0, 0, 0, 0);
    chk_st("rst", 0, 0, 0, 0);
    chk("rst.max", max_value, 0);
`ifdef MAXNET_TIMEOUT_EN
    chk("rst.timeout", 32'(timeout), 0);
`endif
    rst = 1'b0;
    tick(1);

    // Single survivor (unit 2) in the first CHECK.
    set_pu(4'b1011, 32'h0, 32'h0, 32'h3E800000, 32'h0);
    pulse_start(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    chk_x("t1.load", 32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    chk_st("t1.load", 1, 0, 0, 0);
    tick(WC + 1);
    chk("t1.check.done", 32'(done), 0);
    chk("t1.check.X_0", X_0, 32'h3F800000);
    tick(1);
    chk_st("t1.done", 0, 1, 2, 1);
    chk("t1.max", max_value, 32'h3E800000);
    chk_x("t1.done", 0, 0, 32'h3E800000, 0);
    tick(2);
    chk("t1.hold.done", 32'(done), 1);
    chk("t1.hold.max", max_value, 32'h3E800000);

    // All units clamped in the first CHECK.
    set_pu(4'hF, 0, 0, 0, 0);
    pulse_start(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    chk_st("t2.load", 1, 0, 2, 0);
    tick(WC + 2);
    chk_st("t2.done", 0, 1, 0, 1);
    chk("t2.max", max_value, 0);

    // Three CHECKs: nz = 3, 2, then 1 (unit 0).
    pulse_start(32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3E800000);
    set_pu(4'b0100, 32'h3F400000, 32'h3F000000, 32'h0, 32'h3E800000);
    tick(WC + 2);
    chk_x("t3.c1", 32'h3F400000, 32'h3F000000, 32'h0, 32'h3E800000);
    chk_st("t3.c1", 1, 0, 0, 1);
    set_pu(4'b0110, 32'h3F000000, 32'h0, 32'h0, 32'h3E000000);
    tick(WC);
    chk_x("t3.pre2", 32'h3F400000, 32'h3F000000, 32'h0, 32'h3E800000);
    tick(1);
    chk_x("t3.c2", 32'h3F000000, 32'h0, 32'h0, 32'h3E000000);
    chk_st("t3.c2", 1, 0, 0, 2);
    set_pu(4'b1110, 32'h3DCCCCCD, 32'h0, 32'h0, 32'h0);
    tick(WC);
    chk("t3.pre3.done", 32'(done), 0);
    tick(1);
    chk_x("t3.c3", 32'h3DCCCCCD, 0, 0, 0);
    chk_st("t3.c3", 0, 1, 0, 3);
    chk("t3.max", max_value, 32'h3DCCCCCD);

    // start during WAIT is ignored.
    set_pu(4'b0111, 32'h0, 32'h0, 32'h0, 32'h3F100000);
    pulse_start(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick(1);
    pulse_start(32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000);
    chk_x("t4.wait", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    chk_st("t4.wait", 1, 0, 0, 0);
    tick(WC - 1);
    chk_x("t4.check", 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick(1);
    chk_st("t4.done", 0, 1, 3, 1);
    chk("t4.max", max_value, 32'h3F100000);
    chk_x("t4.done", 0, 0, 0, 32'h3F100000);

    // Asynchronous reset in the middle of WAIT.
    set_pu(4'b1101, 32'h0, 32'h3F200000, 32'h0, 32'h0);
    pulse_start(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick(1);
    rst = 1'b1;
    #1;
    chk_x("t5.rst", 0, 0, 0, 0);
    chk_st("t5.rst", 0, 0, 0, 0);
    chk("t5.rst.max", max_value, 0);
    #1;
    rst = 1'b0;
    tick(1);
    chk_x("t5.idle", 0, 0, 0, 0);
    chk_st("t5.idle", 0, 0, 0, 0);
    pulse_start(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick(WC + 2);
    chk_st("t5.done", 0, 1, 1, 1);
    chk("t5.max", max_value, 32'h3F200000);

    // Tied inputs: every unit survives every CHECK.
    set_pu(4'h0, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
    pulse_start(32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
    tick(WC + 1);
`ifdef MAXNET_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("t6.iter", 32'(iter_count), 32'(k));
      if (k < 4) begin
        chk("t6.run.done", 32'(done), 0);
        chk("t6.run.timeout", 32'(timeout), 0);
        tick(WC);
      end else begin
        chk_st("t6.to", 0, 1, 0, 4);
        chk("t6.to.timeout", 32'(timeout), 1);
        chk("t6.to.max", max_value, 0);
      end
    end
`else
    for (int k = 1; k <= 257; k++) begin
      tick(1);
      if (k == 6) chk_st("t6.k6", 1, 0, 1, 6);
      if (k < 257) tick(WC);
    end
    chk_st("t6.sat", 1, 0, 1, 255);
    chk_x("t6.sat", 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_st("t6.abort", 0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/maxnet_ctrl.md
MAXNET_CTRL -- requirements
Module: maxnet_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: cycles allowed for the processing-unit multiply and add register stages after each activation update.
REQ-002 SHALL have parameter MAX_ITER, default 64: iteration limit, present only when MAXNET_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to load X_in_0..3 and begin competition.
REQ-006 SHALL have ports X_in_0..X_in_3, input, 32 each: initial activations, IEEE-754 single precision.
REQ-007 SHALL have ports PU_out_0..PU_out_3, input, 32 each: ReLU outputs returned by the four processing units.
REQ-008 SHALL have ports Zero_sign_0..Zero_sign_3, input, 1 each: 1 when the matching PU output is clamped to zero.
REQ-009 SHALL have ports X_0..X_3, output, 32 each: registered activations driven to the processing units.
REQ-010 SHALL have port busy, output, 1: high in LOAD, WAIT and CHECK.
REQ-011 SHALL have port done, output, 1: high while in DONE.
REQ-012 SHALL have port winner, output, 2: index of the surviving unit.
REQ-013 SHALL have port max_value, output, 32: PU output of the winner.
REQ-014 SHALL have port iter_count, output, 8: completed iterations, saturating at 255.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WAIT, CHECK and DONE.
REQ-016 IDLE/DONE with start=1: X_0..3 <= X_in_0..3, iter_count <= 0, done <= 0, next state LOAD.
REQ-017 LOAD SHALL last one cycle, then go to WAIT with the wait counter set to WAIT_CYCLES-1.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES-1 further cycles, decrementing, then go to CHECK; PU_out and Zero_sign are valid in CHECK.
REQ-019 CHECK SHALL take nz = count of Zero_sign_i==0, load X_i <= PU_out_i and increment iter_count.
REQ-020 CHECK with nz>=2 SHALL return to WAIT with the counter reloaded as in REQ-017.
REQ-021 CHECK with nz==1 SHALL go to DONE with winner = index i where Zero_sign_i==0 and max_value = PU_out_i.
REQ-022 CHECK with nz==0 SHALL go to DONE with winner=0 and max_value=32'h0.
REQ-023 start SHALL be ignored in LOAD, WAIT and CHECK.
REQ-024 DONE SHALL hold all outputs until start or rst.
REQ-025 winner, max_value and iter_count SHALL hold their last values in IDLE and DONE.

Reset
REQ-026 rst=1 SHALL force, asynchronously, state to IDLE and X_0..3, busy, done, winner, max_value, iter_count (and timeout) to 0.
REQ-027 rst asserted mid-competition SHALL abort immediately, with no further X update.

Configuration
REQ-028 With MAXNET_TIMEOUT_EN defined, port timeout (output, 1) SHALL exist.
REQ-029 With MAXNET_TIMEOUT_EN defined, CHECK with nz>=2 and post-increment iter_count==MAX_ITER SHALL go to DONE with timeout=1, winner=0 and max_value=0.
REQ-030 Without MAXNET_TIMEOUT_EN, the timeout port and the MAX_ITER guard SHALL be absent, and iteration SHALL be unbounded (tied inputs never terminate).

Verification
REQ-031 Bench: rst pulse mid-WAIT -> all outputs 0 and state IDLE in the same cycle; a later start proceeds normally.
REQ-032 Bench: start with X_in = 3F800000, 3F000000, 3E800000, 3F400000, and model drives Zero_sign=4'b1011 with PU_out_2=3E800000 in the first CHECK -> done 1 cycle after CHECK, winner=2, max_value=3E800000, iter_count=1.
REQ-033 Bench: model returns nz=3, 2, then 1 (unit 0, 3DCCCCCD) over three CHECKs -> X_0..3 track PU_out each CHECK, done with winner=0 and iter_count=3; CHECKs spaced WAIT_CYCLES+1 cycles.
REQ-034 Bench: Zero_sign all 1 in the first CHECK -> done, winner=0, max_value=0, iter_count=1.
REQ-035 Bench: MAXNET_TIMEOUT_EN with MAX_ITER=4, tied inputs 3F000000 x4 and nz=4 each CHECK -> done and timeout=1 after iter_count=4.
REQ-036 Bench: start pulsed during WAIT -> ignored; X_0..3 unchanged until the next CHECK.
